csr_rmw_unit: RTL and testbench

- Sits between the execute stage and the 64-entry CSR register file.
- Accepts one Zicsr instruction per handshake: CSRRW/S/C and CSRRWI/SI/CI.
- Maps the 12-bit CSR address onto a 6-bit file index, performs the read-modify-write, and returns the old CSR value for rd.
- Flags illegal accesses instead of touching the file.

---
 rtl/csr_rmw_unit.sv | 156 +++++++++++++++
 tb/tb_csr_rmw_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_rmw_unit.sv
// rtl/csr_rmw_unit.sv - Zicsr read-modify-write sequencer in front of a 64-entry CSR file
//
// Takes one CSRRW/S/C or CSRRWI/SI/CI request per handshake. It maps the CSR
// address onto a 6-bit file index, reads the old value and writes the new value
// back when the instruction needs a write. It then returns the old value for rd.
// Accesses outside the legal CSR page, and reserved funct3 encodings, are
// flagged illegal and never reach the file.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_funct3            instruction funct3 (bit 2 selects the immediate forms)
//   req_csr               12-bit CSR address
//   req_rs1_idx           rs1 field, doubles as zimm
//   req_rs1_data          rs1 register value
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             old CSR value (0 when illegal)
//   rsp_illegal           illegal-instruction flag
//   csr_raddr/csr_rdata   combinational file read port
//   csr_we/waddr/wdata    file write port
//   wr_count              running count of file writes (wraps)

module csr_rmw_unit #(
   parameter logic [5:0] CSR_PAGE = 6'h0C
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [11:0] req_csr,
   input  logic [4:0]  req_rs1_idx,
   input  logic [31:0] req_rs1_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_illegal,
   output logic [5:0]  csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic        csr_we,
   output logic [5:0]  csr_waddr,
   output logic [31:0] csr_wdata,
   output logic [31:0] wr_count
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [5:0]  idx_q, idx_d;
   logic [4:0]  zimm_q, zimm_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] old_q, old_d;
   logic        illegal_q, illegal_d;
   logic [31:0] wr_count_q, wr_count_d;

   logic        accept;
   logic        req_illegal;
   logic        write_needed;
   logic [31:0] operand;
   logic [31:0] new_val;

   always_comb begin
      req_illegal = (req_csr[11:6] != CSR_PAGE) ||
                    (req_funct3 == 3'b000) || (req_funct3 == 3'b100);

      operand = funct3_q[2] ? {27'b0, zimm_q} : rs1_q;

      // Set/clear with rs1 = x0 (or zimm = 0) is a pure read.
      write_needed = (funct3_q[1:0] == 2'b01) || (zimm_q != '0);

      case (funct3_q[1:0])
         2'b01:   new_val = operand;
         2'b10:   new_val = old_q | operand;
         default: new_val = old_q & ~operand;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      funct3_d   = funct3_q;
      idx_d      = idx_q;
      zimm_d     = zimm_q;
      rs1_d      = rs1_q;
      old_d      = old_q;
      illegal_d  = illegal_q;
      wr_count_d = wr_count_q;

      req_ready  = (state_q == IDLE);
      rsp_valid  = (state_q == RESP);
      accept     = req_valid && req_ready;
      csr_raddr  = '0;
      csr_we     = 1'b0;
      csr_waddr  = '0;
      csr_wdata  = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               funct3_d  = req_funct3;
               idx_d     = req_csr[5:0];
               zimm_d    = req_rs1_idx;
               rs1_d     = req_rs1_data;
               illegal_d = req_illegal;
               // Cleared here so an illegal response reports 0.
               old_d     = '0;
               state_d   = req_illegal ? RESP : READ;
            end
         end
         READ: begin
            csr_raddr = idx_q;
            old_d     = csr_rdata;
            state_d   = write_needed ? WRITE : RESP;
         end
         WRITE: begin
            // Gate with reset so an aborted request never lands in the file.
            csr_we     = ~reset;
            csr_waddr  = idx_q;
            csr_wdata  = new_val;
            wr_count_d = wr_count_q + 32'd1;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      rsp_rdata   = old_q;
      rsp_illegal = illegal_q;
      wr_count    = wr_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         funct3_q   <= '0;
         idx_q      <= '0;
         zimm_q     <= '0;
         rs1_q      <= '0;
         old_q      <= '0;
         illegal_q  <= 1'b0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         funct3_q   <= funct3_d;
         idx_q      <= idx_d;
         zimm_q     <= zimm_d;
         rs1_q      <= rs1_d;
         old_q      <= old_d;
         illegal_q  <= illegal_d;
         wr_count_q <= wr_count_d;
      end
   end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb/tb_csr_rmw_unit.sv - scoreboard bench for csr_rmw_unit with a behavioural CSR file

module tb_csr_rmw_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_csr;
   logic [4:0]  req_rs1_idx;
   logic [31:0] req_rs1_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_illegal;
   logic [5:0]  csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_we;
   logic [5:0]  csr_waddr;
   logic [31:0] csr_wdata;
   logic [31:0] wr_count;

   csr_rmw_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_csr(req_csr),
      .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   logic [31:0] file_mem [64];
   logic [31:0] shadow [64];
   logic        mem_clr;
   logic        pre_en;
   logic [5:0]  pre_idx;
   logic [31:0] pre_val;

   assign csr_rdata = file_mem[csr_raddr];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) file_mem[i] <= '0;
      end else if (pre_en) begin
         file_mem[pre_idx] <= pre_val;
      end else if (csr_we) begin
         file_mem[csr_waddr] <= csr_wdata;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        illegal;
      int          lat;
      int          wes;
      logic [5:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] wrc;
   } exp_t;

   exp_t        exp_q [$];
   int          assert_cnt = 0;
   int          fail_cnt   = 0;
   logic [31:0] exp_wr     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_file(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(negedge clk);
      pre_en  = 1'b0;
      shadow[idx] = val;
   endtask

   task automatic do_req(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] idx,
                         input logic [31:0] data, input int stall);
      exp_t        e;
      exp_t        got;
      logic [31:0] old, op;
      int          cyc, wes, we_cyc;
      logic [5:0]  wa;
      logic [31:0] wd, held;

      old       = shadow[csr[5:0]];
      op        = f3[2] ? {27'b0, idx} : data;
      e.illegal = (csr[11:6] != 6'h0C) || (f3 == 3'b000) || (f3 == 3'b100);
      e.wes     = (!e.illegal && (f3[1:0] == 2'b01 || idx != 5'd0)) ? 1 : 0;
      e.rdata   = e.illegal ? 32'h0 : old;
      e.lat     = e.illegal ? 1 : (e.wes == 1 ? 3 : 2);
      e.waddr   = csr[5:0];
      case (f3[1:0])
         2'b01:   e.wdata = op;
         2'b10:   e.wdata = old | op;
         default: e.wdata = old & ~op;
      endcase
      if (e.wes == 1) begin
         shadow[csr[5:0]] = e.wdata;
         exp_wr = exp_wr + 1;
      end
      e.wrc = exp_wr;
      exp_q.push_back(e);

      @(negedge clk);
      req_funct3   = f3;
      req_csr      = csr;
      req_rs1_idx  = idx;
      req_rs1_data = data;
      req_valid    = 1'b1;
      check("req_ready_idle", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;

      cyc = 0; wes = 0; we_cyc = 0; wa = '0; wd = '0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (csr_we) begin
            wes++; we_cyc = cyc; wa = csr_waddr; wd = csr_wdata;
         end
         if (rsp_valid) break;
      end
      check("rsp_valid_seen", rsp_valid, 1);
      held = rsp_rdata;

      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (csr_we) wes++;
         check("stall_valid", rsp_valid, 1);
         check("stall_rdata", rsp_rdata, held);
         check("stall_ready", req_ready, 0);
      end

      rsp_ready = 1'b1;
      got = exp_q.pop_front();
      check("rsp_rdata", rsp_rdata, got.rdata);
      check("rsp_illegal", rsp_illegal, got.illegal);
      check("latency", cyc, got.lat);
      check("write_count", wes, got.wes);
      if (got.wes == 1) begin
         check("we_cycle", we_cyc, 2);
         check("waddr", wa, got.waddr);
         check("wdata", wd, got.wdata);
      end
      check("wr_count", wr_count, got.wrc);
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_drop", rsp_valid, 0);
      check("ready_back", req_ready, 1);
      check("file_content", file_mem[csr[5:0]], shadow[csr[5:0]]);
   endtask

   initial begin
      reset = 1'b1; mem_clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      req_valid = 1'b0; req_funct3 = '0; req_csr = '0; req_rs1_idx = '0; req_rs1_data = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_illegal", rsp_illegal, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_csr_we", csr_we, 0);
      check("rst_raddr", csr_raddr, 0);
      check("rst_waddr", csr_waddr, 0);
      check("rst_wdata", csr_wdata, 0);
      check("rst_wr_count", wr_count, 0);
      reset = 1'b0; mem_clr = 1'b0;

      set_file(6'd5, 32'h0000_0100);
      do_req(3'b001, 12'h305, 5'd0, 32'hDEAD_BEEF, 0);
      set_file(6'd0, 32'h0000_00F0);
      do_req(3'b010, 12'h300, 5'd3, 32'h0000_000F, 0);
      set_file(6'd0, 32'h0000_00FF);
      do_req(3'b111, 12'h300, 5'b00101, 32'h1234_5678, 0);
      do_req(3'b111, 12'h300, 5'd0, 32'hFFFF_FFFF, 0);
      do_req(3'b001, 12'h7C0, 5'd1, 32'hCAFE_F00D, 0);
      do_req(3'b100, 12'h300, 5'd7, 32'h0000_0001, 0);
      do_req(3'b010, 12'h30A, 5'd9, 32'hA5A5_0000, 5);

      for (int t = 0; t < 12; t++) begin
         logic [11:0] c;
         c = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {6'h0C, 6'($urandom)};
         do_req(3'($urandom), c, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                $urandom, $urandom_range(0, 2));
      end

      set_file(6'd9, 32'h0000_0055);
      @(negedge clk);
      req_funct3 = 3'b001; req_csr = 12'h309; req_rs1_idx = 5'd1; req_rs1_data = 32'h0000_AAAA;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst_write_gated", csr_we, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_req_ready", req_ready, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_rsp_rdata", rsp_rdata, 0);
      check("abort_rsp_illegal", rsp_illegal, 0);
      check("abort_csr_we", csr_we, 0);
      check("abort_wr_count", wr_count, 0);
      check("abort_file", file_mem[9], 32'h0000_0055);
      exp_wr = 0;
      do_req(3'b011, 12'h309, 5'd0, 32'h0000_0004, 1);
      do_req(3'b101, 12'h309, 5'd3, 32'h0, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
